// File: rtl/hs_npu_activation_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_pkg
//  Brief    : Shared types and default widths for the NPU activation stage.
//  Revision : 1.0 - initial release
// ============================================================================
package hs_npu_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int OUTPUT_WIDTH_DEF = 16;
  localparam int COLS_DEF         = 8;
  localparam int SHIFT_WIDTH_DEF  = 5;
  localparam int ROW_CNT_W_DEF    = 16;

  // Per-tile configuration latched when the sequencer leaves IDLE.
  typedef struct packed {
    logic                       relu_en;
    logic [SHIFT_WIDTH_DEF-1:0] shift;
    logic [ROW_CNT_W_DEF-1:0]   rows;
  } act_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_state_e;

endpackage : hs_npu_pkg
`default_nettype wire

// File: rtl/hs_npu_activation_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_activation_ctrl_if
//  Brief    : Config, accumulator-row and activated-row channels plus status.
//  Revision : 1.0 - initial release
// ============================================================================
interface hs_npu_activation_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int COLS         = 8,
  parameter int SHIFT_WIDTH  = 5,
  parameter int ROW_CNT_W    = 16
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic                         cfg_relu_en;
  logic [SHIFT_WIDTH-1:0]       cfg_shift;
  logic [ROW_CNT_W-1:0]         cfg_rows;
  logic                         in_valid;
  logic                         in_ready;
  logic [COLS*DATA_WIDTH-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [COLS*OUTPUT_WIDTH-1:0] out_data;
  logic                         out_last;
  logic                         busy;
  logic                         done;

  // Upstream/downstream side (drives config, rows and out_ready).
  modport master (
    output cfg_valid, cfg_relu_en, cfg_shift, cfg_rows, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_last, busy, done
  );

  // Activation sequencer side.
  modport slave (
    input  cfg_valid, cfg_relu_en, cfg_shift, cfg_rows, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_last, busy, done
  );
endinterface : hs_npu_activation_ctrl_if
`default_nettype wire

// File: rtl/hs_npu_activation_ctrl_act.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_act_unit
//  Brief    : Combinational per-column activation: ReLU, arithmetic right
//             shift, truncation to the low output bits (no saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_act_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT_WIDTH  = 5
) (
  input  wire logic                    i_valid,
  input  wire logic [DATA_WIDTH-1:0]   i_data,
  input  wire logic                    i_relu_en,
  input  wire logic [SHIFT_WIDTH-1:0]  i_shift,
  output logic                         o_valid,
  output logic [OUTPUT_WIDTH-1:0]      o_data
);
  logic        [DATA_WIDTH-1:0] w_relu;
  logic signed [DATA_WIDTH-1:0] w_shifted;

  // Negative words are clamped to zero before the shift when ReLU is on.
  assign w_relu    = (i_relu_en && i_data[DATA_WIDTH-1]) ? '0 : i_data;
  assign w_shifted = $signed(w_relu) >>> i_shift;
  assign o_data    = w_shifted[OUTPUT_WIDTH-1:0];
  assign o_valid   = i_valid;
endmodule : hs_npu_act_unit
`default_nettype wire

// File: rtl/hs_npu_activation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_activation_ctrl
//  Brief    : Activation-stage sequencer for one output tile: latches the
//             tile config, activates one accumulator row per beat and
//             registers it towards writeback with valid/ready, out_last on
//             the final row and a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_activation_ctrl
  import hs_npu_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int SHIFT_WIDTH  = SHIFT_WIDTH_DEF,
  parameter int ROW_CNT_W    = ROW_CNT_W_DEF
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  hs_npu_activation_ctrl_if.slave  bus
);
  localparam logic [ROW_CNT_W-1:0] C_ONE = {{(ROW_CNT_W-1){1'b0}}, 1'b1};

  act_state_e                   state_q, state_d;
  act_cfg_t                     cfg_q, cfg_d;
  logic [ROW_CNT_W-1:0]         row_cnt_q, row_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [COLS*OUTPUT_WIDTH-1:0] out_data_q, out_data_d;

  logic                    w_in_ready;
  logic                    w_in_hs;
  logic                    w_out_hs;
  logic                    w_last_row;
  logic                    w_col_valid [COLS];
  logic [OUTPUT_WIDTH-1:0] w_col_data  [COLS];

  // Input is only taken in RUN, and only when the output register frees up this cycle.
  assign w_in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign w_in_hs    = bus.in_valid && w_in_ready;
  assign w_out_hs   = out_valid_q && bus.out_ready;
  assign w_last_row = (row_cnt_q == (cfg_q.rows - C_ONE));

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      hs_npu_act_unit #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .SHIFT_WIDTH  (SHIFT_WIDTH)
      ) u_act (
        .i_valid   (w_in_hs),
        .i_data    (bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .i_relu_en (cfg_q.relu_en),
        .i_shift   (cfg_q.shift),
        .o_valid   (w_col_valid[c]),
        .o_data    (w_col_data[c])
      );
    end
  endgenerate

  // Next-state, config latch, row counter and output-register update.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    // A consumed beat empties the register; a new row refills it in the same cycle.
    if (w_out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (w_in_hs) begin
      out_valid_d = 1'b1;
      out_last_d  = w_last_row;
      row_cnt_d   = row_cnt_q + C_ONE;
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_col_valid[c]) out_data_d[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] = w_col_data[c];
    end

    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          cfg_d.relu_en = bus.cfg_relu_en;
          cfg_d.shift   = bus.cfg_shift;
          cfg_d.rows    = bus.cfg_rows;
          row_cnt_d     = '0;
          state_d       = (bus.cfg_rows != '0) ? RUN : DONE;
        end
      end
      RUN:     if (w_in_hs && w_last_row) state_d = DRAIN;
      DRAIN:   if (w_out_hs && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single state register for the FSM, config, counter and output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule : hs_npu_activation_ctrl
`default_nettype wire

// File: tb/tb_hs_npu_activation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_npu_activation_ctrl
//  Brief    : Directed self-checking bench for hs_npu_activation_ctrl (COLS=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_npu_activation_ctrl;
  localparam int DW   = 32;
  localparam int OW   = 16;
  localparam int COLS = 4;
  localparam int SW   = 5;
  localparam int RW   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hs_npu_activation_ctrl_if #(
    .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .COLS(COLS), .SHIFT_WIDTH(SW), .ROW_CNT_W(RW)
  ) bus ();

  hs_npu_activation_ctrl #(
    .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .COLS(COLS), .SHIFT_WIDTH(SW), .ROW_CNT_W(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic relu, input logic [SW-1:0] sh, input logic [RW-1:0] rows);
    bus.cfg_valid   = 1'b1;
    bus.cfg_relu_en = relu;
    bus.cfg_shift   = sh;
    bus.cfg_rows    = rows;
    #1;
    chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("busy_after_cfg", 64'(bus.busy), 64'd1);
  endtask

  task automatic send_row(input logic [DW-1:0] d, input logic [OW-1:0] e, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {COLS{d}};
    #1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("out_valid", 64'(bus.out_valid), 64'd1);
    chk("out_data", 64'(bus.out_data), 64'({COLS{e}}));
    chk("out_last", 64'(bus.out_last), 64'(last));
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("out_valid_at_done", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("busy_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_relu_en = 1'b0;
    bus.cfg_shift   = '0;
    bus.cfg_rows    = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_done",      64'(bus.done),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("idle_in_ready",  64'(bus.in_ready),  64'd0);

    // Basic tile: relu on, shift 4, 3 rows of 0x100 -> 0x0010
    send_cfg(1'b1, 5'd4, 16'd3);
    chk("run_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    send_row(32'h0000_0100, 16'h0010, 1'b0);
    send_row(32'h0000_0100, 16'h0010, 1'b0);
    send_row(32'h0000_0100, 16'h0010, 1'b1);
    chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
    chk("drain_no_done",  64'(bus.done),     64'd0);
    wait_done();

    // Negative input with and without ReLU
    send_cfg(1'b1, 5'd2, 16'd1);
    send_row(32'hFFFF_FFE0, 16'h0000, 1'b1);
    wait_done();
    send_cfg(1'b0, 5'd2, 16'd1);
    send_row(32'hFFFF_FFE0, 16'hFFF8, 1'b1);
    wait_done();

    // Truncation and maximum shift
    send_cfg(1'b0, 5'd0, 16'd1);
    send_row(32'h0012_3456, 16'h3456, 1'b1);
    wait_done();
    send_cfg(1'b0, 5'd31, 16'd1);
    send_row(32'h8000_0000, 16'hFFFF, 1'b1);
    wait_done();

    // Backpressure: stall the first beat for 3 cycles
    send_cfg(1'b0, 5'd0, 16'd4);
    send_row(32'd1, 16'd1, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {COLS{32'd2}};
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data",  64'(bus.out_data),  64'({COLS{16'd1}}));
      chk("bp_out_last",  64'(bus.out_last),  64'd0);
    end
    bus.out_ready = 1'b1;
    send_row(32'd2, 16'd2, 1'b0);
    send_row(32'd3, 16'd3, 1'b0);
    send_row(32'd4, 16'd4, 1'b1);
    wait_done();

    // Zero-row tile: done pulse, no output
    bus.cfg_valid   = 1'b1;
    bus.cfg_relu_en = 1'b0;
    bus.cfg_shift   = '0;
    bus.cfg_rows    = '0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("rows0_done",      64'(bus.done),      64'd1);
    chk("rows0_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("rows0_done_end",  64'(bus.done),      64'd0);
    chk("rows0_no_output", 64'(bus.out_valid), 64'd0);
    chk("rows0_busy",      64'(bus.busy),      64'd0);

    // Config offered during RUN is ignored
    send_cfg(1'b0, 5'd1, 16'd2);
    send_row(32'h0000_0040, 16'h0020, 1'b0);
    bus.cfg_valid   = 1'b1;
    bus.cfg_relu_en = 1'b1;
    bus.cfg_shift   = 5'd3;
    bus.cfg_rows    = 16'd9;
    #1;
    chk("run_cfg_ignored_ready", 64'(bus.cfg_ready), 64'd0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    send_row(32'hFFFF_FF80, 16'hFFC0, 1'b1);
    wait_done();

    // Asynchronous reset mid-tile, then a clean tile
    send_cfg(1'b0, 5'd0, 16'd3);
    send_row(32'd5, 16'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data",  64'(bus.out_data),  64'd0);
    chk("arst_out_last",  64'(bus.out_last),  64'd0);
    chk("arst_busy",      64'(bus.busy),      64'd0);
    chk("arst_done",      64'(bus.done),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cfg(1'b1, 5'd4, 16'd3);
    send_row(32'h0000_0200, 16'h0020, 1'b0);
    send_row(32'h0000_0200, 16'h0020, 1'b0);
    send_row(32'h0000_0200, 16'h0020, 1'b1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule : tb_hs_npu_activation_ctrl
`default_nettype wire
